// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared widths and controller state type for the sequential 6x6 multiplier
package mul_seq_pkg;

    localparam int HALF_W = 3;
    localparam int OP_W   = 6;
    localparam int PROD_W = 12;
    localparam int PP_W   = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/mul3x3_pp.sv
// rtl/mul3x3_pp.sv - combinational unsigned 3x3 array multiplier built from AND terms and full adders
module mul3x3_pp
    import mul_seq_pkg::*;
(
    input  logic [HALF_W-1:0] x,
    input  logic [HALF_W-1:0] y,
    output logic [PP_W-1:0]   p
);

    function automatic logic [1:0] full_add(input logic fa, input logic fb, input logic fc);
        return {(fa & fb) | (fa & fc) | (fb & fc), fa ^ fb ^ fc};
    endfunction

    logic [HALF_W-1:0] w_row0;
    logic [HALF_W-1:0] w_row1;
    logic [HALF_W-1:0] w_row2;
    logic [HALF_W-1:0] w_add1;
    logic [HALF_W-1:0] w_add2;
    logic [HALF_W:0]   w_sum1;
    logic [HALF_W:0]   w_sum2;

    assign w_row0 = x & {HALF_W{y[0]}};
    assign w_row1 = x & {HALF_W{y[1]}};
    assign w_row2 = x & {HALF_W{y[2]}};

    // Each row ripples into the running sum; the low bit of every stage retires directly to p.
    assign w_add1 = {1'b0, w_row0[HALF_W-1:1]};
    assign w_add2 = w_sum1[HALF_W:1];

    always_comb begin : stage1
        logic       c;
        logic [1:0] fa;
        c      = 1'b0;
        w_sum1 = '0;
        for (int i = 0; i < HALF_W; i++) begin
            fa        = full_add(w_add1[i], w_row1[i], c);
            w_sum1[i] = fa[0];
            c         = fa[1];
        end
        w_sum1[HALF_W] = c;
    end

    always_comb begin : stage2
        logic       c;
        logic [1:0] fa;
        c      = 1'b0;
        w_sum2 = '0;
        for (int i = 0; i < HALF_W; i++) begin
            fa        = full_add(w_add2[i], w_row2[i], c);
            w_sum2[i] = fa[0];
            c         = fa[1];
        end
        w_sum2[HALF_W] = c;
    end

    assign p = {w_sum2, w_sum1[0], w_row0[0]};

endmodule

// File: rtl/mul6x6_seq.sv
// rtl/mul6x6_seq.sv - 6x6 unsigned multiplier sharing one 3x3 unit over four accumulate cycles
module mul6x6_seq
    import mul_seq_pkg::*;
#(
    parameter int SKIP_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    state_t              r_state;
    state_t              w_next;
    logic [OP_W-1:0]     r_ra;
    logic [OP_W-1:0]     r_rb;
    logic [PROD_W-1:0]   r_acc;
    logic [HALF_W-1:0]   w_x;
    logic [HALF_W-1:0]   w_y;
    logic [PP_W-1:0]     w_pp;
    logic [PROD_W-1:0]   w_pp_ext;
    logic [PROD_W-1:0]   w_addend;
    logic                w_zero_op;

    assign w_zero_op = (SKIP_ZERO != 0) && ((a == '0) || (b == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ra  <= a;
                        r_rb  <= b;
                        r_acc <= '0;
                    end
                end
                PP0, PP1, PP2, PP3: r_acc <= r_acc + w_addend;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = w_zero_op ? DONE : PP0;
            PP0:     w_next = PP1;
            PP1:     w_next = PP2;
            PP2:     w_next = PP3;
            PP3:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand halves for the shared unit, selected by which cross product this cycle adds.
    always_comb begin
        w_x = r_ra[HALF_W-1:0];
        w_y = r_rb[HALF_W-1:0];
        case (r_state)
            PP1: w_x = r_ra[OP_W-1:HALF_W];
            PP2: w_y = r_rb[OP_W-1:HALF_W];
            PP3: begin
                w_x = r_ra[OP_W-1:HALF_W];
                w_y = r_rb[OP_W-1:HALF_W];
            end
            default: ;
        endcase
    end

    mul3x3_pp u_pp (
        .x (w_x),
        .y (w_y),
        .p (w_pp)
    );

    assign w_pp_ext = PROD_W'(w_pp);

    always_comb begin
        w_addend = '0;
        case (r_state)
            PP0:      w_addend = w_pp_ext;
            PP1, PP2: w_addend = w_pp_ext << HALF_W;
            PP3:      w_addend = w_pp_ext << (2 * HALF_W);
            default:  ;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign product   = r_acc;

endmodule
